// File: rtl/cmd_dispatch_mc.sv
// cmd_dispatch_mc: decodes 24-bit UART commands into SPI transactions and config registers,
// and returns a one-byte response for each command.
module cmd_dispatch_mc #(
    parameter int NUM_CH       = 3,
    parameter int TRIG_POS_W   = 9,
    parameter int TRIG_LVL_MIN = 46,
    parameter int TRIG_LVL_MAX = 201,
    parameter int SPI_TMO      = 1023
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [23:0]           cmd,
    input  logic                  cmd_rdy,
    output logic                  clr_cmd_rdy,
    output logic [7:0]            resp_data,
    output logic                  send_resp,
    input  logic                  resp_sent,
    output logic [15:0]           spi_data,
    output logic                  wrt_spi,
    output logic [2:0]            ss,
    input  logic                  spi_done,
    input  logic [7:0]            eep_rd_data,
    input  logic                  set_cap_done,
    output logic [3:0]            decimator,
    output logic [1:0]            dump_chan,
    output logic                  dump_en,
    output logic [5:0]            trig_cfg,
    output logic [TRIG_POS_W-1:0] trig_pos,
    output logic [3*NUM_CH-1:0]   gain,
    output logic                  busy
);
    localparam int CW = $clog2(SPI_TMO + 1);
    localparam logic [7:0] LMIN = 8'(TRIG_LVL_MIN);
    localparam logic [7:0] LMAX = 8'(TRIG_LVL_MAX);
    localparam logic [63:0] GTAB = {8'hDD, 8'h6B, 8'h46, 8'h28, 8'h14, 8'h09, 8'h05, 8'h02};

    typedef enum logic [1:0] {IDLE, DECODE, SPI_WAIT, RESP} state_t;
    state_t r_state;

    logic                  r_clr, r_send, r_wrt, r_den, r_is_gain, r_is_rd;
    logic [7:0]            r_resp;
    logic [15:0]           r_spi_data;
    logic [2:0]            r_ss, r_ggg;
    logic [3:0]            r_dec;
    logic [1:0]            r_dchan, r_cc;
    logic [5:0]            r_tcfg;
    logic [TRIG_POS_W-1:0] r_tpos;
    logic [3*NUM_CH-1:0]   r_gain;
    logic [CW-1:0]         r_cnt;

    logic [7:0]  w_op, w_byte, w_lvl, w_resp;
    logic [1:0]  w_cc;
    logic [2:0]  w_ggg, w_gsel, w_ss;
    logic        w_ccok, w_spi, w_unused;
    logic [15:0] w_spi_word;

    assign w_op     = cmd[23:16];
    assign w_cc     = cmd[9:8];
    assign w_ggg    = cmd[12:10];
    assign w_byte   = cmd[7:0];
    assign w_ccok   = {30'd0, w_cc} < 32'(NUM_CH);
    assign w_unused = ^cmd[15:14];
    assign w_lvl    = (w_byte < LMIN) ? LMIN : (w_byte > LMAX) ? LMAX : w_byte;
    assign w_spi    = (w_op == 8'h02 && w_ccok) || w_op == 8'h03 || w_op == 8'h08 || w_op == 8'h09;
    assign w_ss     = (w_op == 8'h02) ? {1'b0, w_cc} : (w_op == 8'h03) ? 3'd4 : 3'd5;
    assign w_spi_word = (w_op == 8'h02) ? {8'h13, GTAB[8*w_ggg +: 8]} :
                        (w_op == 8'h03) ? {8'h13, w_lvl} :
                        (w_op == 8'h08) ? {2'b01, cmd[13:0]} : {2'b00, cmd[13:8], 8'h00};

    always_comb begin
        w_gsel = '0;
        for (int n = 0; n < NUM_CH; n++)
            if (w_cc == 2'(n)) w_gsel = r_gain[3*n +: 3];
    end

    // responses for commands that finish without an SPI transaction
    assign w_resp = (w_op == 8'h01 || w_op == 8'h0A) ?
                        (w_ccok ? ((w_op == 8'h01) ? 8'hA5 : {5'b0, w_gsel}) : 8'hEE) :
                    (w_op == 8'h04 || w_op == 8'h05 || w_op == 8'h06) ? 8'hA5 :
                    (w_op == 8'h07) ? {2'b00, r_tcfg} : 8'hEE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_clr      <= 1'b0;
            r_send     <= 1'b0;
            r_wrt      <= 1'b0;
            r_den      <= 1'b0;
            r_is_gain  <= 1'b0;
            r_is_rd    <= 1'b0;
            r_resp     <= '0;
            r_spi_data <= '0;
            r_ss       <= '0;
            r_ggg      <= '0;
            r_dec      <= '0;
            r_dchan    <= '0;
            r_cc       <= '0;
            r_tcfg     <= '0;
            r_tpos     <= '0;
            r_gain     <= '0;
            r_cnt      <= '0;
        end else begin
            r_clr  <= 1'b0;
            r_send <= 1'b0;
            r_wrt  <= 1'b0;
            r_den  <= 1'b0;
            if (set_cap_done) r_tcfg[5] <= 1'b1;
            case (r_state)
                IDLE: if (cmd_rdy && !r_clr) r_state <= DECODE;
                DECODE: begin
                    if (w_spi) begin
                        r_state    <= SPI_WAIT;
                        r_wrt      <= 1'b1;
                        r_spi_data <= w_spi_word;
                        r_ss       <= w_ss;
                        r_cnt      <= '0;
                        r_is_gain  <= w_op == 8'h02;
                        r_is_rd    <= w_op == 8'h09;
                        r_cc       <= w_cc;
                        r_ggg      <= w_ggg;
                    end else begin
                        r_state <= RESP;
                        r_send  <= 1'b1;
                        r_resp  <= w_resp;
                        if (w_op == 8'h01 && w_ccok) begin
                            r_dchan <= w_cc;
                            r_den   <= 1'b1;
                        end
                        if (w_op == 8'h04) r_tpos <= cmd[TRIG_POS_W-1:0];
                        if (w_op == 8'h05) r_dec <= cmd[3:0];
                        if (w_op == 8'h06) r_tcfg <= cmd[13:8];
                    end
                end
                SPI_WAIT: begin
                    if (spi_done) begin
                        r_state <= RESP;
                        r_send  <= 1'b1;
                        r_resp  <= r_is_rd ? eep_rd_data : 8'hA5;
                        for (int n = 0; n < NUM_CH; n++)
                            if (r_is_gain && r_cc == 2'(n)) r_gain[3*n +: 3] <= r_ggg;
                    end else if (r_cnt == CW'(SPI_TMO - 1)) begin
                        r_state <= RESP;
                        r_send  <= 1'b1;
                        r_resp  <= 8'hEE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RESP: if (resp_sent) begin
                    r_clr   <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign clr_cmd_rdy = r_clr;
    assign resp_data   = r_resp;
    assign send_resp   = r_send;
    assign spi_data    = r_spi_data;
    assign wrt_spi     = r_wrt;
    assign ss          = r_ss;
    assign decimator   = r_dec;
    assign dump_chan   = r_dchan;
    assign dump_en     = r_den;
    assign trig_cfg    = r_tcfg;
    assign trig_pos    = r_tpos;
    assign gain        = r_gain;
    assign busy        = r_state != IDLE;
endmodule

// File: tb/tb_cmd_dispatch_mc.sv
// tb_cmd_dispatch_mc: scoreboard bench; expected responses are queued per command and
// compared whenever the dispatcher pulses send_resp.
module tb_cmd_dispatch_mc;
    localparam int NUM_CH = 3;
    localparam int TPW = 9;
    localparam int TMO = 1023;

    logic clk = 0, rst = 1;
    logic [23:0] cmd = '0;
    logic cmd_rdy = 0, resp_sent = 0, spi_done = 0, set_cap_done = 0;
    logic [7:0] eep_rd_data = '0;
    logic clr_cmd_rdy, send_resp, wrt_spi, dump_en, busy;
    logic [7:0] resp_data;
    logic [15:0] spi_data;
    logic [2:0] ss;
    logic [3:0] decimator;
    logic [1:0] dump_chan;
    logic [5:0] trig_cfg;
    logic [TPW-1:0] trig_pos;
    logic [3*NUM_CH-1:0] gain;

    int total = 0, bad = 0, dump_cnt = 0, wrt_cnt = 0;
    logic [7:0] q[$];

    cmd_dispatch_mc #(.NUM_CH(NUM_CH), .TRIG_POS_W(TPW), .TRIG_LVL_MIN(46),
                      .TRIG_LVL_MAX(201), .SPI_TMO(TMO)) dut (
        .clk(clk), .rst(rst), .cmd(cmd), .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy),
        .resp_data(resp_data), .send_resp(send_resp), .resp_sent(resp_sent),
        .spi_data(spi_data), .wrt_spi(wrt_spi), .ss(ss), .spi_done(spi_done),
        .eep_rd_data(eep_rd_data), .set_cap_done(set_cap_done), .decimator(decimator),
        .dump_chan(dump_chan), .dump_en(dump_en), .trig_cfg(trig_cfg), .trig_pos(trig_pos),
        .gain(gain), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (dump_en) dump_cnt++;
        if (wrt_spi) wrt_cnt++;
        if (send_resp) begin
            chk("resp_pending", 32'(q.size() != 0), 1);
            if (q.size() != 0) chk("resp", resp_data, q.pop_front());
        end
    end

    // d: negedges after the wrt_spi one at which spi_done is pulsed, -1 for none
    task automatic run(input logic [23:0] c, input logic [7:0] exp, input logic spi,
                       input logic [15:0] xd, input logic [2:0] xs, input logic [7:0] rd,
                       input int d, input logic cap);
        int k;
        q.push_back(exp);
        @(negedge clk);
        cmd = c;
        cmd_rdy = 1;
        k = 0;
        while (k < 20 && !(spi ? wrt_spi : send_resp)) begin
            @(negedge clk);
            k++;
            set_cap_done = cap && k == 1;
        end
        set_cap_done = 0;
        chk(spi ? "wrt_lat" : "resp_lat", k, 2);
        if (spi) begin
            chk("spi_data", spi_data, xd);
            chk("ss", ss, xs);
            k = 0;
            eep_rd_data = rd;
            while (k < TMO + 50 && !send_resp) begin
                @(negedge clk);
                k++;
                spi_done = k == d;
            end
            spi_done = 0;
            chk("done_lat", k, (d < 0) ? TMO : d + 1);
        end
        resp_sent = 1;
        @(negedge clk);
        resp_sent = 0;
        chk("send_pulse", send_resp, 0);
        chk("clr", clr_cmd_rdy, 1);
        cmd_rdy = 0;
        @(negedge clk);
        chk("clr_pulse", clr_cmd_rdy, 0);
        chk("idle", busy, 0);
    endtask

    initial begin
        int k;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_gain", gain, 0);
        chk("rst_spi", spi_data, 0);
        chk("rst_ss", ss, 0);
        chk("rst_cfg", trig_cfg, 0);
        chk("rst_resp", resp_data, 0);
        rst = 0;
        @(negedge clk);

        run(24'h020D00, 8'hA5, 1, 16'h1314, 3'd1, 8'h00, 3, 0);
        chk("gain_set", gain, 9'h018);
        run(24'h030010, 8'hA5, 1, 16'h132E, 3'd4, 8'h00, 3, 0);
        run(24'h0300F0, 8'hA5, 1, 16'h13C9, 3'd4, 8'h00, 3, 0);
        run(24'h030080, 8'hA5, 1, 16'h1380, 3'd4, 8'h00, 2, 0);
        run(24'h090500, 8'h3C, 1, 16'h0500, 3'd5, 8'h3C, 3, 0);
        run(24'h082ABC, 8'hA5, 1, 16'h6ABC, 3'd5, 8'h77, 1, 0);
        run(24'h020100, 8'hEE, 1, 16'h1302, 3'd1, 8'h00, -1, 0);
        chk("gain_tmo", gain, 9'h018);
        @(negedge clk);
        spi_done = 1;
        @(negedge clk);
        spi_done = 0;
        repeat (2) @(negedge clk);
        chk("gain_stray", gain, 9'h018);
        run(24'h021C00, 8'hA5, 1, 16'h13DD, 3'd0, 8'h00, TMO - 1, 0);
        chk("gain_edge", gain, 9'h01F);

        k = wrt_cnt;
        run(24'h020300, 8'hEE, 0, 0, 0, 0, 0, 0);
        chk("bad_cc_nospi", wrt_cnt, k);
        run(24'h010300, 8'hEE, 0, 0, 0, 0, 0, 0);
        chk("dump_none", dump_cnt, 0);
        run(24'h010200, 8'hA5, 0, 0, 0, 0, 0, 0);
        chk("dump_one", dump_cnt, 1);
        chk("dump_chan", dump_chan, 2);
        run(24'h1F0000, 8'hEE, 0, 0, 0, 0, 0, 0);
        run(24'h0A0100, 8'h03, 0, 0, 0, 0, 0, 0);
        run(24'h0A0000, 8'h07, 0, 0, 0, 0, 0, 0);
        run(24'h0A0300, 8'hEE, 0, 0, 0, 0, 0, 0);
        run(24'h040123, 8'hA5, 0, 0, 0, 0, 0, 0);
        chk("trig_pos", trig_pos, 9'h123);
        run(24'h05003A, 8'hA5, 0, 0, 0, 0, 0, 0);
        chk("decimator", decimator, 4'hA);

        run(24'h060500, 8'hA5, 0, 0, 0, 0, 0, 1);
        chk("cfg_06_wins", trig_cfg, 6'h05);
        @(negedge clk);
        set_cap_done = 1;
        @(negedge clk);
        set_cap_done = 0;
        chk("cap_set", trig_cfg, 6'h25);
        run(24'h070000, 8'h25, 0, 0, 0, 0, 0, 0);
        run(24'h062000, 8'hA5, 0, 0, 0, 0, 0, 1);
        chk("cfg_20", trig_cfg, 6'h20);
        run(24'h070000, 8'h20, 0, 0, 0, 0, 0, 0);

        @(negedge clk);
        cmd = 24'h030080;
        cmd_rdy = 1;
        k = 0;
        while (k < 20 && !wrt_spi) begin
            @(negedge clk);
            k++;
        end
        chk("rst_wrt_lat", k, 2);
        repeat (4) @(negedge clk);
        chk("mid_busy", busy, 1);
        rst = 1;
        cmd_rdy = 0;
        @(negedge clk);
        chk("arst_busy", busy, 0);
        chk("arst_ss", ss, 0);
        chk("arst_spi", spi_data, 0);
        chk("arst_gain", gain, 0);
        chk("arst_cfg", trig_cfg, 0);
        chk("arst_pos", trig_pos, 0);
        rst = 0;
        repeat (4) @(negedge clk);
        chk("arst_clr", clr_cmd_rdy, 0);
        chk("q_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
